pwm_capture: RTL and testbench

//  Measures an incoming PWM waveform and reports its period and high time in sys_clk cycles.
//  It is the receive side of our PWM LED drivers, for loopback checks of LED duty ramps and for

---
 rtl/pwm_pkg.sv | 14 +
 rtl/sync_edge_det.sv | 40 ++++
 rtl/pwm_capture.sv | 126 ++++++++++++
 tb/tb_pwm_capture.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared PWM definitions: capture FSM encoding and common timing constants.
package pwm_pkg;

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } pwm_state_e;

  localparam int CNT_W_DEFAULT  = 17;
  // 1 kHz PWM period at a 100 MHz system clock, shared with the LED generators.
  localparam int PWM_PERIOD_1MS = 100000;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for an asynchronous input followed by an edge register.
// rise/fall are single-cycle pulses derived from the synchronised level s.
module sync_edge_det (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic d,
  output logic s,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic s_q, s_d;
  logic s_dly_q, s_dly_d;

  // Shift the input through the synchroniser and the edge register.
  always_comb begin
    meta_d  = d;
    s_d     = meta_q;
    s_dly_d = s_q;
  end

  // Synchroniser and edge register flops.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      meta_q  <= 1'b0;
      s_q     <= 1'b0;
      s_dly_q <= 1'b0;
    end else begin
      meta_q  <= meta_d;
      s_q     <= s_d;
      s_dly_q <= s_dly_d;
    end
  end

  assign s    = s_q;
  assign rise = s_q & ~s_dly_q;
  assign fall = ~s_q & s_dly_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM receiver: measures period and high time in sys_clk cycles, one result
// per complete PWM period, with a timeout for stuck (0 % / 100 %) lines.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEFAULT,
  parameter int TIMEOUT = 120000
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             pwm_in,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             timeout,
  output logic             level
);

  localparam logic [CNT_W-1:0] TO_C  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  logic s, rise, fall;

  sync_edge_det u_sync (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .d        (pwm_in),
    .s        (s),
    .rise     (rise),
    .fall     (fall)
  );

  pwm_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_lat_q, hi_lat_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic             meas_valid_q, meas_valid_d;
  logic             timeout_q, timeout_d;
  logic             level_q, level_d;
  logic             trip;

  // Counter, FSM next state and result registers. Edges take priority over
  // a coincident timeout so a period of exactly TIMEOUT is still reported.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hi_lat_d     = hi_lat_q;
    period_d     = period_q;
    high_time_d  = high_time_q;
    meas_valid_d = 1'b0;
    timeout_d    = timeout_q;
    level_d      = level_q;
    trip         = (cnt_q == TO_C);

    if (rise)      cnt_d = ONE_C;
    else if (!trip) cnt_d = cnt_q + ONE_C;

    case (state_q)
      S_SYNC: begin
        // Falls are ignored until the first rise starts a clean measurement.
        // The counter stays saturated here, so trip only once per stuck episode.
        if (rise) begin
          state_d = S_HIGH;
        end else if (trip && !timeout_q) begin
          timeout_d = 1'b1;
          level_d   = s;
        end
      end
      S_HIGH: begin
        if (fall) begin
          hi_lat_d = cnt_q;
          state_d  = S_LOW;
        end else if (trip) begin
          timeout_d = 1'b1;
          level_d   = s;
          state_d   = S_SYNC;
        end
      end
      S_LOW: begin
        if (rise) begin
          period_d     = cnt_q;
          high_time_d  = hi_lat_q;
          meas_valid_d = 1'b1;
          timeout_d    = 1'b0;
          state_d      = S_HIGH;
        end else if (trip) begin
          timeout_d = 1'b1;
          level_d   = s;
          state_d   = S_SYNC;
        end
      end
      default: state_d = S_SYNC;
    endcase
  end

  // State and output registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= S_SYNC;
      cnt_q        <= '0;
      hi_lat_q     <= '0;
      period_q     <= '0;
      high_time_q  <= '0;
      meas_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
      level_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hi_lat_q     <= hi_lat_d;
      period_q     <= period_d;
      high_time_q  <= high_time_d;
      meas_valid_q <= meas_valid_d;
      timeout_q    <= timeout_d;
      level_q      <= level_d;
    end
  end

  assign meas_valid = meas_valid_q;
  assign period     = period_q;
  assign high_time  = high_time_q;
  assign timeout    = timeout_q;
  assign level      = level_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture, scaled down (TIMEOUT=300, period=100).
module tb_pwm_capture;

  localparam int CNT_W   = 10;
  localparam int TIMEOUT = 300;

  logic             sys_clk   = 1'b0;
  logic             sys_rst_n = 1'b0;
  logic             pwm_in    = 1'b0;
  logic             meas_valid;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             timeout;
  logic             level;

  int n_cmp = 0;
  int n_err = 0;

  // Strobe log, written only by the monitor below.
  int q_per[$];
  int q_hi[$];
  bit q_to[$];
  int to_cycles = 0;

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .pwm_in    (pwm_in),
    .meas_valid(meas_valid),
    .period    (period),
    .high_time (high_time),
    .timeout   (timeout),
    .level     (level)
  );

  always #5 sys_clk = ~sys_clk;

  // Log every strobe and count timeout-high cycles, sampled after the edge.
  always @(posedge sys_clk) begin
    #2;
    if (meas_valid) begin
      q_per.push_back(int'(period));
      q_hi.push_back(int'(high_time));
      q_to.push_back(timeout);
    end
    if (timeout) to_cycles++;
  end

  task automatic drive(input logic v, input int n);
    pwm_in = v;
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic run_periods(input int h, input int l, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, h);
      drive(1'b0, l);
    end
  endtask

  task automatic apply_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    pwm_in    = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    pwm_in    = 1'b0;
    repeat (3) @(negedge sys_clk);
    n_cmp++; if (meas_valid !== 1'b0) begin n_err++; $display("FAIL reset meas_valid: got %b want 0", meas_valid); end
    n_cmp++; if (period !== '0) begin n_err++; $display("FAIL reset period: got %0d want 0", period); end
    n_cmp++; if (high_time !== '0) begin n_err++; $display("FAIL reset high_time: got %0d want 0", high_time); end
    n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL reset timeout: got %b want 0", timeout); end
    n_cmp++; if (level !== 1'b0) begin n_err++; $display("FAIL reset level: got %b want 0", level); end
    sys_rst_n = 1'b1;
  endtask

  // 5 periods of H=30/L=70 -> 4 strobes of 100/30, no timeout.
  task automatic test_basic();
    int base, tc0;
    apply_reset();
    base = q_per.size();
    tc0  = to_cycles;
    run_periods(30, 70, 5);
    drive(1'b0, 5);
    n_cmp++; if (q_per.size() - base !== 4) begin n_err++; $display("FAIL basic strobe count: got %0d want 4", q_per.size() - base); end
    for (int i = 0; i < 4; i++) begin
      if (base + i < q_per.size()) begin
        n_cmp++; if (q_per[base+i] !== 100) begin n_err++; $display("FAIL basic period[%0d]: got %0d want 100", i, q_per[base+i]); end
        n_cmp++; if (q_hi[base+i] !== 30) begin n_err++; $display("FAIL basic high_time[%0d]: got %0d want 30", i, q_hi[base+i]); end
      end
    end
    n_cmp++; if (to_cycles - tc0 !== 0) begin n_err++; $display("FAIL basic timeout cycles: got %0d want 0", to_cycles - tc0); end
  endtask

  // Duty ramp H=10..60 step 10, period 100 -> strobes report 10..50.
  task automatic test_ramp();
    int base;
    apply_reset();
    base = q_per.size();
    for (int k = 1; k <= 6; k++) run_periods(10 * k, 100 - 10 * k, 1);
    drive(1'b0, 5);
    n_cmp++; if (q_per.size() - base !== 5) begin n_err++; $display("FAIL ramp strobe count: got %0d want 5", q_per.size() - base); end
    for (int i = 0; i < 5; i++) begin
      if (base + i < q_per.size()) begin
        n_cmp++; if (q_per[base+i] !== 100) begin n_err++; $display("FAIL ramp period[%0d]: got %0d want 100", i, q_per[base+i]); end
        n_cmp++; if (q_hi[base+i] !== 10 * (i + 1)) begin n_err++; $display("FAIL ramp high_time[%0d]: got %0d want %0d", i, q_hi[base+i], 10 * (i + 1)); end
      end
    end
  endtask

  // Fastest supported waveform H=2/L=3.
  task automatic test_fast();
    int base;
    apply_reset();
    base = q_per.size();
    run_periods(2, 3, 6);
    drive(1'b0, 5);
    n_cmp++; if (q_per.size() - base !== 5) begin n_err++; $display("FAIL fast strobe count: got %0d want 5", q_per.size() - base); end
    for (int i = 0; i < 5; i++) begin
      if (base + i < q_per.size()) begin
        n_cmp++; if (q_per[base+i] !== 5) begin n_err++; $display("FAIL fast period[%0d]: got %0d want 5", i, q_per[base+i]); end
        n_cmp++; if (q_hi[base+i] !== 2) begin n_err++; $display("FAIL fast high_time[%0d]: got %0d want 2", i, q_hi[base+i]); end
      end
    end
  endtask

  // Line stuck high after a valid stream, then resume.
  task automatic test_stuck_high();
    int base;
    apply_reset();
    base = q_per.size();
    run_periods(30, 70, 3);
    drive(1'b1, 290);
    // The hold's rise closes the third period: 3 strobes, timeout not yet due.
    n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL stuck_hi early timeout: got %b want 0", timeout); end
    drive(1'b1, 110);
    n_cmp++; if (timeout !== 1'b1) begin n_err++; $display("FAIL stuck_hi timeout: got %b want 1", timeout); end
    n_cmp++; if (level !== 1'b1) begin n_err++; $display("FAIL stuck_hi level: got %b want 1", level); end
    n_cmp++; if (period !== 10'(100)) begin n_err++; $display("FAIL stuck_hi period hold: got %0d want 100", period); end
    n_cmp++; if (high_time !== 10'(30)) begin n_err++; $display("FAIL stuck_hi high_time hold: got %0d want 30", high_time); end
    n_cmp++; if (q_per.size() - base !== 3) begin n_err++; $display("FAIL stuck_hi strobe count: got %0d want 3", q_per.size() - base); end
    // Resume: first rise only re-arms; timeout must still be set.
    drive(1'b0, 70);
    drive(1'b1, 30);
    drive(1'b0, 70);
    n_cmp++; if (timeout !== 1'b1) begin n_err++; $display("FAIL resume timeout before strobe: got %b want 1", timeout); end
    n_cmp++; if (q_per.size() - base !== 3) begin n_err++; $display("FAIL resume early strobe: got %0d want 3", q_per.size() - base); end
    drive(1'b1, 30);
    drive(1'b0, 5);
    n_cmp++; if (q_per.size() - base !== 4) begin n_err++; $display("FAIL resume strobe count: got %0d want 4", q_per.size() - base); end
    if (q_per.size() - base == 4) begin
      n_cmp++; if (q_per[base+3] !== 100) begin n_err++; $display("FAIL resume period: got %0d want 100", q_per[base+3]); end
      n_cmp++; if (q_hi[base+3] !== 30) begin n_err++; $display("FAIL resume high_time: got %0d want 30", q_hi[base+3]); end
      n_cmp++; if (q_to[base+3] !== 1'b0) begin n_err++; $display("FAIL resume timeout at strobe: got %b want 0", q_to[base+3]); end
    end
  endtask

  // Reset in the middle of a high phase aborts the measurement.
  task automatic test_reset_mid();
    int base;
    apply_reset();
    run_periods(30, 70, 1);
    drive(1'b1, 10);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    n_cmp++; if (meas_valid !== 1'b0) begin n_err++; $display("FAIL midrst meas_valid: got %b want 0", meas_valid); end
    n_cmp++; if (period !== '0) begin n_err++; $display("FAIL midrst period: got %0d want 0", period); end
    n_cmp++; if (high_time !== '0) begin n_err++; $display("FAIL midrst high_time: got %0d want 0", high_time); end
    n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL midrst timeout: got %b want 0", timeout); end
    n_cmp++; if (level !== 1'b0) begin n_err++; $display("FAIL midrst level: got %b want 0", level); end
    drive(1'b0, 5);
    sys_rst_n = 1'b1;
    base = q_per.size();
    run_periods(30, 70, 1);
    n_cmp++; if (q_per.size() - base !== 0) begin n_err++; $display("FAIL midrst strobe on first rise: got %0d want 0", q_per.size() - base); end
    run_periods(30, 70, 1);
    drive(1'b1, 30);
    drive(1'b0, 5);
    n_cmp++; if (q_per.size() - base !== 2) begin n_err++; $display("FAIL midrst strobe count: got %0d want 2", q_per.size() - base); end
    if (q_per.size() - base == 2) begin
      n_cmp++; if (q_per[base] !== 100) begin n_err++; $display("FAIL midrst period: got %0d want 100", q_per[base]); end
      n_cmp++; if (q_hi[base] !== 30) begin n_err++; $display("FAIL midrst high_time: got %0d want 30", q_hi[base]); end
    end
  endtask

  // Line stuck low from reset.
  task automatic test_stuck_low();
    int base;
    apply_reset();
    base = q_per.size();
    drive(1'b0, 290);
    n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL stuck_lo early timeout: got %b want 0", timeout); end
    drive(1'b0, 20);
    n_cmp++; if (timeout !== 1'b1) begin n_err++; $display("FAIL stuck_lo timeout: got %b want 1", timeout); end
    n_cmp++; if (level !== 1'b0) begin n_err++; $display("FAIL stuck_lo level: got %b want 0", level); end
    drive(1'b0, 100);
    n_cmp++; if (q_per.size() - base !== 0) begin n_err++; $display("FAIL stuck_lo strobes: got %0d want 0", q_per.size() - base); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ramp();
    test_fast();
    test_stuck_high();
    test_reset_mid();
    test_stuck_low();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
